mem_arbiter: RTL and testbench

- Shares one single-ported RAM between the instruction-fetch requester and the data (MEM-stage) requester of the pipelined MIPS core.
- Serialises accesses through a small FSM and latches the address, data and type of each access at grant.
- Returns registered load data with a one-cycle hit pulse, which the pipeline uses to release its stalls.
- Data has priority over fetch; a streak limit bounds fetch starvation, and a watchdog aborts RAM accesses that never complete.

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/mem_arb_grant.sv | 59 +++++
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the MIPS core's memory arbiter.
//   arb_state_t : arbiter FSM state (IDLE / I_ACC / D_ACC)
//   arb_acc_t   : access latched at grant (address, write data, write flag)
//   BAD_DATA    : load value returned when the watchdog aborts an access
package cpu_types_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        I_ACC = 2'd1,
        D_ACC = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] store;
        logic        wen;
    } arb_acc_t;

    localparam logic [31:0] BAD_DATA = 32'hBAD0_BAD0;

    // Streak counter holds values up to 15; watchdog counts up to 65535.
    localparam int STREAK_W = 4;
    localparam int WD_W     = 16;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant selection for the memory arbiter.
//   CLK, RST        : clock, synchronous active-high reset
//   i_req           : fetch read request (iREN)
//   d_ren, d_wen    : data read / write requests
//   ihit, dhit      : hit pulses currently on the arbiter outputs
//   idle            : arbiter FSM is in IDLE
//   grant_i/grant_d : one-hot grant, only asserted while idle
// Data wins over fetch except when fetch has waited out MAX_DSTREAK
// consecutive data grants; the streak counter lives here.
module mem_arb_grant
    import cpu_types_pkg::*;
#(
    parameter int MAX_DSTREAK = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_req,
    input  logic d_ren,
    input  logic d_wen,
    input  logic ihit,
    input  logic dhit,
    input  logic idle,
    output logic grant_i,
    output logic grant_d
);

    logic [STREAK_W-1:0] streak_q, streak_d;
    logic i_elig, d_elig, force_i;

    always_comb begin
        // A requester whose hit is showing this cycle still has its old
        // request up; ignore it so the finished access is not replayed.
        i_elig  = i_req & ~ihit;
        d_elig  = (d_ren | d_wen) & ~dhit;
        force_i = i_elig && (streak_q == STREAK_W'(MAX_DSTREAK));
        grant_d = idle & d_elig & ~force_i;
        grant_i = idle & i_elig & ~grant_d;

        streak_d = streak_q;
        if (grant_i) begin
            streak_d = '0;
        end else if (grant_d) begin
            if (!i_req) begin
                streak_d = '0;
            end else if (streak_q != STREAK_W'(MAX_DSTREAK)) begin
                streak_d = streak_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-ported RAM arbiter between instruction fetch and the MEM stage.
//   CLK, RST              : clock, synchronous active-high reset
//   iREN, iaddr           : fetch request (held until ihit) and address
//   ihit, iload           : fetch completion pulse and held fetch data
//   dREN, dWEN, daddr,
//   dstore                : data request (held until dhit), address, data
//   dhit, dload           : data completion pulse and held read data
//   ram_ren, ram_wen,
//   ram_addr, ram_store   : registered RAM strobes, address, write data
//   ram_load, ram_ready   : RAM read data and completion flag
//   timeout_err           : pulses with the hit of a watchdog-aborted access
// Handshake: a requester raises its request and keeps it and its address
// stable until its hit pulse; the RAM finishes an access by raising
// ram_ready for one cycle while a strobe is high.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        ihit,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        ram_ren,
    output logic        ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_store,
    input  logic [31:0] ram_load,
    input  logic        ram_ready,
    output logic        timeout_err
);

    arb_state_t      state_q, state_d;
    arb_acc_t        acc_q, acc_d;
    logic            ren_q, ren_d, wen_q, wen_d;
    logic            ihit_q, ihit_d, dhit_q, dhit_d, terr_q, terr_d;
    logic [31:0]     iload_q, iload_d, dload_q, dload_d;
    logic [WD_W-1:0] wd_q, wd_d, wd_inc;
    logic            grant_i, grant_d, done, abort;

    mem_arb_grant #(.MAX_DSTREAK(MAX_DSTREAK)) u_grant (
        .CLK     (CLK),
        .RST     (RST),
        .i_req   (iREN),
        .d_ren   (dREN),
        .d_wen   (dWEN),
        .ihit    (ihit_q),
        .dhit    (dhit_q),
        .idle    (state_q == IDLE),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    // State register (plus all datapath flops).
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            ihit_q  <= 1'b0;
            dhit_q  <= 1'b0;
            terr_q  <= 1'b0;
            iload_q <= '0;
            dload_q <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            ihit_q  <= ihit_d;
            dhit_q  <= dhit_d;
            terr_q  <= terr_d;
            iload_q <= iload_d;
            dload_q <= dload_d;
            wd_q    <= wd_d;
        end
    end

    // Next state. ram_ready beats the watchdog when both land together.
    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        abort   = 1'b0;
        wd_inc  = wd_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = D_ACC;
                end else if (grant_i) begin
                    state_d = I_ACC;
                end
            end
            I_ACC, D_ACC: begin
                if (ram_ready) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if ((TIMEOUT > 0) && (wd_inc == WD_W'(TIMEOUT))) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs and latched datapath.
    always_comb begin
        acc_d   = acc_q;
        ren_d   = ren_q;
        wen_d   = wen_q;
        ihit_d  = 1'b0;
        dhit_d  = 1'b0;
        terr_d  = 1'b0;
        iload_d = iload_q;
        dload_d = dload_q;
        wd_d    = wd_q;
        if (state_q == IDLE) begin
            if (grant_d || grant_i) begin
                acc_d.addr  = grant_d ? daddr : iaddr;
                acc_d.store = grant_d ? dstore : '0;
                // A data request with both strobes up is a write.
                acc_d.wen   = grant_d & dWEN;
                ren_d       = grant_i | (grant_d & ~dWEN);
                wen_d       = grant_d & dWEN;
                wd_d        = '0;
            end
        end else if (done || abort) begin
            ren_d  = 1'b0;
            wen_d  = 1'b0;
            terr_d = abort;
            if (state_q == I_ACC) begin
                ihit_d  = 1'b1;
                iload_d = abort ? BAD_DATA : ram_load;
            end else begin
                dhit_d = 1'b1;
                if (abort) begin
                    dload_d = BAD_DATA;
                end else if (!acc_q.wen) begin
                    dload_d = ram_load;
                end
            end
        end else begin
            wd_d = wd_inc;
        end
    end

    assign ihit        = ihit_q;
    assign iload       = iload_q;
    assign dhit        = dhit_q;
    assign dload       = dload_q;
    assign ram_ren     = ren_q;
    assign ram_wen     = wen_q;
    assign ram_addr    = acc_q.addr;
    assign ram_store   = acc_q.store;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int MAX_DSTREAK = 4;
    localparam int TIMEOUT     = 8;
    localparam logic [31:0] BAD = 32'hBAD0_BAD0;

    // ---------------- clock / reset / DUT ----------------
    logic        CLK, RST;
    logic        iREN, dREN, dWEN, ram_ready;
    logic [31:0] iaddr, daddr, dstore, ram_load;
    logic        ihit, dhit, ram_ren, ram_wen, timeout_err;
    logic [31:0] iload, dload, ram_addr, ram_store;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    mem_arbiter #(.MAX_DSTREAK(MAX_DSTREAK), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dhit(dhit), .dload(dload),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready),
        .timeout_err(timeout_err)
    );

    // ---------------- scoreboard / reference model ----------------
    int total = 0;
    int bad   = 0;

    // Model of what the arbiter should show after each edge.
    // m_mode: 0 = no access in flight, 1 = fetch in flight, 2 = data in flight
    int          m_mode = 0, m_streak = 0, m_wd = 0;
    bit          m_ihit = 0, m_dhit = 0, m_terr = 0, m_ren = 0, m_wen = 0;
    logic [31:0] m_iload = 0, m_dload = 0, m_addr = 0, m_store = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit pi, pd, ie, de;
        pi = m_ihit;
        pd = m_dhit;
        m_ihit = 0; m_dhit = 0; m_terr = 0;
        if (RST) begin
            m_mode = 0; m_streak = 0; m_wd = 0;
            m_iload = 0; m_dload = 0; m_ren = 0; m_wen = 0;
            m_addr = 0; m_store = 0;
            return;
        end
        if (m_mode == 0) begin
            ie = iREN && !pi;
            de = (dREN || dWEN) && !pd;
            if (de && !(ie && m_streak == MAX_DSTREAK)) begin
                if (iREN) m_streak = (m_streak < MAX_DSTREAK) ? m_streak + 1 : MAX_DSTREAK;
                else      m_streak = 0;
                m_mode = 2; m_addr = daddr; m_store = dstore;
                m_wen = dWEN; m_ren = !dWEN; m_wd = 0;
            end else if (ie) begin
                m_streak = 0;
                m_mode = 1; m_addr = iaddr; m_store = 0;
                m_wen = 0; m_ren = 1; m_wd = 0;
            end
        end else if (ram_ready) begin
            if (m_mode == 1) begin
                m_iload = ram_load; m_ihit = 1;
            end else begin
                m_dhit = 1;
                if (!m_wen) m_dload = ram_load;
            end
            m_ren = 0; m_wen = 0; m_mode = 0;
        end else if (TIMEOUT > 0 && m_wd + 1 == TIMEOUT) begin
            if (m_mode == 1) begin
                m_iload = BAD; m_ihit = 1;
            end else begin
                m_dload = BAD; m_dhit = 1;
            end
            m_terr = 1; m_ren = 0; m_wen = 0; m_mode = 0;
        end else begin
            m_wd++;
        end
    endtask

    task automatic check_model();
        chk("ihit", ihit, m_ihit);
        chk("dhit", dhit, m_dhit);
        chk("timeout_err", timeout_err, m_terr);
        chk("ram_ren", ram_ren, m_ren);
        chk("ram_wen", ram_wen, m_wen);
        chk("ram_addr", ram_addr, m_addr);
        chk("iload", iload, m_iload);
        chk("dload", dload, m_dload);
        if (m_wen) chk("ram_store", ram_store, m_store);
    endtask

    // One clock: inputs already driven; model follows the edge; outputs
    // sampled 1 time unit after it.
    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        check_model();
    endtask

    // ---------------- random driver ----------------
    task automatic drive_random();
        int kind;
        if (m_ihit) begin
            iREN = ($urandom_range(0, 1) == 1); iaddr = $urandom;
        end else if (!iREN) begin
            iREN = ($urandom_range(0, 2) == 0); iaddr = $urandom;
        end else if (m_mode == 1) begin
            iaddr = $urandom;                       // must not disturb the access in flight
        end else if ($urandom_range(0, 15) == 0) begin
            iREN = 0;                               // withdrawn before grant
        end

        if (m_dhit || !(dREN || dWEN)) begin
            if (m_dhit || $urandom_range(0, 2) == 0) begin
                kind = $urandom_range(0, 3);
                dREN = (kind == 0) || (kind == 2);
                dWEN = (kind == 1) || (kind == 2);
                daddr = $urandom; dstore = $urandom;
            end
        end else if (m_mode == 2) begin
            daddr = $urandom; dstore = $urandom;
        end else if ($urandom_range(0, 15) == 0) begin
            dREN = 0; dWEN = 0;
        end

        ram_load  = $urandom;
        ram_ready = (m_mode != 0 && m_wd >= 5) ? 1'b1 : ($urandom_range(0, 1) == 1);
    endtask

    // ---------------- directed + random sequence ----------------
    string hit_seq;
    int    budget;

    initial begin
        RST = 1; iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
        iaddr = 0; daddr = 0; dstore = 0; ram_load = 0;

        // Reset
        step(); step();
        RST = 0;
        chk("rst_ram_ren", ram_ren, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_iload", iload, 0);
        chk("rst_dload", dload, 0);

        // Single fetch: strobe one cycle after request, hit one after ready
        iREN = 1; iaddr = 32'h40;
        step();
        chk("fetch_ren", ram_ren, 1);
        chk("fetch_addr", ram_addr, 32'h40);
        ram_ready = 1; ram_load = 32'h2402_000A;
        step();
        chk("fetch_ihit", ihit, 1);
        chk("fetch_iload", iload, 32'h2402_000A);
        iREN = 0; ram_ready = 0;
        step();
        chk("fetch_ihit_pulse", ihit, 0);

        // Simultaneous fetch + write: write first, fetch follows
        iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h80; dstore = 32'h1234;
        step();
        chk("sim_wen", ram_wen, 1);
        chk("sim_ren", ram_ren, 0);
        chk("sim_addr", ram_addr, 32'h80);
        chk("sim_store", ram_store, 32'h1234);
        ram_ready = 1;
        step();
        chk("sim_dhit", dhit, 1);
        dWEN = 0; ram_ready = 0;
        step();
        chk("sim_fetch_ren", ram_ren, 1);
        chk("sim_fetch_addr", ram_addr, 32'h44);
        ram_ready = 1; ram_load = 32'h11;
        step();
        chk("sim_ihit", ihit, 1);
        iREN = 0; ram_ready = 0;
        step();

        // Data read, then read+write together: write wins, dload kept
        dREN = 1; daddr = 32'h84;
        step();
        ram_ready = 1; ram_load = 32'hCAFE_0001;
        step();
        chk("rd_dload", dload, 32'hCAFE_0001);
        dREN = 0; ram_ready = 0;
        step();
        dREN = 1; dWEN = 1; daddr = 32'h90; dstore = 32'h5;
        step();
        chk("both_wen", ram_wen, 1);
        chk("both_ren", ram_ren, 0);
        ram_ready = 1; ram_load = 32'hDEAD_BEEF;
        step();
        chk("both_dhit", dhit, 1);
        chk("both_dload", dload, 32'hCAFE_0001);
        dREN = 0; dWEN = 0; ram_ready = 0;
        step();

        // Watchdog abort after TIMEOUT cycles without ram_ready
        dREN = 1; daddr = 32'hA0;
        step();
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        chk("to_before_dhit", dhit, 0);
        step();
        chk("to_dhit", dhit, 1);
        chk("to_err", timeout_err, 1);
        chk("to_dload", dload, BAD);
        chk("to_ren", ram_ren, 0);
        dREN = 0;
        step();

        // ram_ready on the last watchdog cycle wins
        dREN = 1; daddr = 32'hA4;
        step();
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        ram_ready = 1; ram_load = 32'h77;
        step();
        chk("late_dhit", dhit, 1);
        chk("late_err", timeout_err, 0);
        chk("late_dload", dload, 32'h77);
        dREN = 0; ram_ready = 0;
        step();

        // Reset mid-access, request still up gets re-granted
        dREN = 1; daddr = 32'hB0;
        step();
        chk("rmid_ren_before", ram_ren, 1);
        RST = 1;
        step();
        chk("rmid_ren", ram_ren, 0);
        chk("rmid_dhit", dhit, 0);
        RST = 0;
        step();
        chk("rmid_regrant_ren", ram_ren, 1);
        chk("rmid_regrant_addr", ram_addr, 32'hB0);
        ram_ready = 1; ram_load = 32'h99;
        step();
        chk("rmid_dhit", dhit, 1);
        dREN = 0; ram_ready = 0;
        step();

        // Starvation: fetch asserted on every grant opportunity except dhit
        // cycles; after MAX_DSTREAK data grants fetch must be forced through.
        hit_seq = "";
        budget = 0;
        dREN = 1; daddr = 32'hC0; iaddr = 32'hC4; ram_ready = 1;
        while (hit_seq.len() < 6 && budget < 60) begin
            iREN = !m_dhit;
            ram_load = $urandom;
            step();
            if (dhit) hit_seq = {hit_seq, "D"};
            if (ihit) hit_seq = {hit_seq, "I"};
            budget++;
        end
        total++;
        assert (hit_seq == "DDDDID") else begin
            bad++;
            $error("FAIL hit_order observed=%s expected=DDDDID", hit_seq);
        end
        dREN = 0; iREN = 0; ram_ready = 0;
        step(); step(); step();

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            drive_random();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
